ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_if.sv | 40 ++++
 rtl/ram_arbiter.sv | 86 ++++++++
 tb/tb_ram_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU, host and RAM signal bundle around the RAM arbiter
interface ram_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_lock;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;
    logic [1:0]    owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        input  ram_rdata,
        output cpu_ack, cpu_rdata, host_ack, host_rdata,
        output ram_addr, ram_we, ram_wdata, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        output ram_rdata,
        input  cpu_ack, cpu_rdata, host_ack, host_rdata,
        input  ram_addr, ram_we, ram_wdata, owner
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin CPU/host sharing of one RAM with host burst lock
module ram_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    ram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

    state_t        state_q;
    logic [1:0]    owner_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          ram_we_q;
    logic          cpu_ack_q;
    logic          host_ack_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] host_rdata_q;
    logic          last_host_q;
    logic          lock_q;
    logic          host_win;

    // Host wins when alone, when locked, or when the CPU had the previous turn
    assign host_win = bus.host_req && (!bus.cpu_req || lock_q || !last_host_q);

    // Three-state sequencer; every output is a register
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q      <= IDLE;
            owner_q      <= 2'b00;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            last_host_q  <= 1'b1;
            lock_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.cpu_req || bus.host_req) begin
                        state_q     <= ACCESS;
                        owner_q     <= host_win ? 2'b10 : 2'b01;
                        ram_addr_q  <= host_win ? bus.host_addr : bus.cpu_addr;
                        ram_wdata_q <= host_win ? bus.host_wdata : bus.cpu_wdata;
                        ram_we_q    <= host_win ? bus.host_we : bus.cpu_we;
                    end
                    if (lock_q && !bus.host_req && bus.cpu_req)
                        lock_q <= 1'b0;
                end
                ACCESS: begin
                    state_q    <= ACK;
                    ram_we_q   <= 1'b0;
                    cpu_ack_q  <= owner_q[0];
                    host_ack_q <= owner_q[1];
                    if (!ram_we_q && owner_q[1])
                        host_rdata_q <= bus.ram_rdata;
                    if (!ram_we_q && owner_q[0])
                        cpu_rdata_q <= bus.ram_rdata;
                end
                ACK: begin
                    state_q     <= IDLE;
                    cpu_ack_q   <= 1'b0;
                    host_ack_q  <= 1'b0;
                    last_host_q <= owner_q[1];
                    lock_q      <= owner_q[1] && bus.host_lock;
                    owner_q     <= 2'b00;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.owner      = owner_q;
    assign bus.ram_addr   = ram_addr_q;
    assign bus.ram_wdata  = ram_wdata_q;
    assign bus.ram_we     = ram_we_q;
    assign bus.cpu_ack    = cpu_ack_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.cpu_rdata  = cpu_rdata_q;
    assign bus.host_rdata = host_rdata_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed checks of sequencing, round-robin, lock and reset
module tb_ram_arbiter;
    logic       clk_i = 1'b0;
    logic       reset_ni = 1'b0;
    logic       mem_ready = 1'b0;
    logic [7:0] mem [32];
    int         n_cmp = 0;
    int         n_err = 0;
    int         ack_who [$];
    int         ack_cyc [$];
    int         hcount;

    ram_arbiter_if #(.AW(5), .DW(8)) bus ();
    ram_arbiter #(.AW(5), .DW(8)) dut (.clk_i(clk_i), .reset_ni(reset_ni), .bus(bus));

    always #5 clk_i = ~clk_i;

    // RAM model: combinational read, write on the clock edge while ram_we is high
    assign bus.ram_rdata = mem[bus.ram_addr];
    always @(posedge clk_i) begin
        if (!mem_ready) begin
            mem[3]    <= 8'h3C;
            mem[5]    <= 8'hA3;
            mem[9]    <= 8'h99;
            mem_ready <= 1'b1;
        end else if (bus.ram_we)
            mem[bus.ram_addr] <= bus.ram_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset;
        reset_ni = 1'b0;
        tick;
        tick;
        reset_ni = 1'b1;
    endtask

    task automatic cpu_rd(input logic [4:0] addr, input logic [7:0] exp);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = addr;
        tick;
        check("cpu_rd_owner", bus.owner, 2'b01);
        check("cpu_rd_addr", bus.ram_addr, addr);
        check("cpu_rd_we", bus.ram_we, 0);
        check("cpu_rd_early_ack", bus.cpu_ack, 0);
        tick;
        check("cpu_rd_ack", bus.cpu_ack, 1);
        check("cpu_rd_data", bus.cpu_rdata, exp);
        check("cpu_rd_host_ack", bus.host_ack, 0);
        bus.cpu_req = 1'b0;
        tick;
        check("cpu_rd_ack_end", bus.cpu_ack, 0);
        check("cpu_rd_owner_end", bus.owner, 2'b00);
    endtask

    task automatic host_wr(input logic [4:0] addr, input logic [7:0] data);
        bus.host_req = 1'b1; bus.host_we = 1'b1; bus.host_addr = addr; bus.host_wdata = data;
        tick;
        check("host_wr_owner", bus.owner, 2'b10);
        check("host_wr_we", bus.ram_we, 1);
        check("host_wr_addr", bus.ram_addr, addr);
        check("host_wr_data", bus.ram_wdata, data);
        check("host_wr_early_ack", bus.host_ack, 0);
        tick;
        check("host_wr_we_off", bus.ram_we, 0);
        check("host_wr_ack", bus.host_ack, 1);
        bus.host_req = 1'b0; bus.host_we = 1'b0;
        tick;
        check("host_wr_ack_end", bus.host_ack, 0);
        check("host_wr_we_end", bus.ram_we, 0);
    endtask

    initial begin
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = 0; bus.cpu_wdata = 0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
        bus.host_lock = 0;
        do_reset;
        check("rst_owner", bus.owner, 0);
        check("rst_acks", {bus.cpu_ack, bus.host_ack, bus.ram_we}, 0);
        check("rst_ram", {bus.ram_addr, bus.ram_wdata}, 0);
        check("rst_rdata", {bus.cpu_rdata, bus.host_rdata}, 0);

        cpu_rd(5'd5, 8'hA3);
        host_wr(5'd31, 8'h5C);
        cpu_rd(5'd31, 8'h5C);

        // Round-robin contention starting from reset: CPU first
        do_reset;
        bus.cpu_req = 1; bus.cpu_addr = 5'd5;
        bus.host_req = 1; bus.host_addr = 5'd31;
        for (int c = 1; c <= 11; c++) begin
            tick;
            check("rr_no_dual_ack", bus.cpu_ack & bus.host_ack, 0);
            if (bus.cpu_ack) begin
                ack_who.push_back(1); ack_cyc.push_back(c);
                check("rr_cpu_data", bus.cpu_rdata, 8'hA3);
            end
            if (bus.host_ack) begin
                ack_who.push_back(2); ack_cyc.push_back(c);
                check("rr_host_data", bus.host_rdata, 8'h5C);
            end
        end
        bus.cpu_req = 0; bus.host_req = 0;
        check("rr_ack_count", ack_who.size(), 4);
        for (int i = 0; i < ack_who.size() && i < 4; i++) begin
            check("rr_order", ack_who[i], (i % 2 == 0) ? 1 : 2);
            check("rr_cycle", ack_cyc[i], 2 + 3 * i);
        end
        tick;
        check("rr_idle_owner", bus.owner, 0);

        // Host lock: four host accesses before the CPU gets in
        ack_who.delete();
        hcount = 0;
        bus.host_req = 1; bus.host_lock = 1; bus.host_addr = 5'd31;
        tick;
        bus.cpu_req = 1; bus.cpu_addr = 5'd5;
        for (int c = 0; c < 20 && ack_who.size() < 5; c++) begin
            tick;
            check("lk_no_dual_ack", bus.cpu_ack & bus.host_ack, 0);
            if (bus.cpu_ack) ack_who.push_back(1);
            if (bus.host_ack) begin
                ack_who.push_back(2);
                hcount++;
                if (hcount == 4) bus.host_lock = 0;
            end
        end
        bus.cpu_req = 0; bus.host_req = 0; bus.host_lock = 0;
        check("lk_ack_count", ack_who.size(), 5);
        for (int i = 0; i < ack_who.size() && i < 5; i++)
            check("lk_order", ack_who[i], (i < 4) ? 2 : 1);
        tick;

        // Address change after sampling must not disturb the transaction
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_addr = 5'd3;
        tick;
        check("hold_addr_access", bus.ram_addr, 5'd3);
        bus.cpu_addr = 5'd9;
        tick;
        check("hold_addr_ack", bus.ram_addr, 5'd3);
        check("hold_ack", bus.cpu_ack, 1);
        check("hold_data", bus.cpu_rdata, 8'h3C);
        bus.cpu_req = 0;
        tick;

        // Asynchronous reset during a host write aborts it
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 5'd7; bus.host_wdata = 8'h77;
        tick;
        check("ar_we_before", bus.ram_we, 1);
        #2 reset_ni = 0;
        #1;
        check("ar_we_async", bus.ram_we, 0);
        check("ar_owner_async", bus.owner, 0);
        bus.host_req = 0; bus.host_we = 0;
        tick;
        check("ar_no_ack_rst", bus.host_ack, 0);
        reset_ni = 1;
        for (int c = 0; c < 3; c++) begin
            tick;
            check("ar_idle", {bus.host_ack, bus.cpu_ack, bus.ram_we, bus.owner}, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
